// File: rtl/dbg_trace_buffer_if.sv
// Trace-buffer bus: write-back capture, trigger controls and the indexed debug readback port.
// The debug/host side uses the master modport and the trace buffer uses the slave modport.
interface dbg_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] wb_pc;
  logic              trig_en;
  logic [4:0]        trig_rd;
  logic              debug;
  logic [IDX_W-1:0]  debug_input;
  logic [1:0]        debug_field;
  logic [DATA_W-1:0] debug_output;
  logic              frozen;
  logic [CW-1:0]     count;

  modport master (
    output wb_valid, wb_rd, wb_data, wb_pc, trig_en, trig_rd,
           debug, debug_input, debug_field,
    input  debug_output, frozen, count
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, wb_pc, trig_en, trig_rd,
           debug, debug_input, debug_field,
    output debug_output, frozen, count
  );
endinterface

// File: rtl/dbg_trace_buffer.sv
// Circular trace of retired register writes {pc, rd, data} with a pulse/rd-match trigger,
// post-trigger capture window, freeze, and a registered indexed readback port.
module dbg_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int IDX_W     = 5,
  parameter int POST_TRIG = 4
) (
  input  logic            clk,
  input  logic            Rst,
  dbg_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    POST   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DATA_W-1:0] mem_pc   [DEPTH];
  logic [4:0]        mem_rd   [DEPTH];

  state_t        state, state_n;
  logic [AW-1:0] wr_ptr, wr_n;
  logic [CW-1:0] count_q, count_n;
  logic [CW-1:0] post_cnt, post_n;
  logic          trig, capture;

  logic [AW-1:0]     slot;
  logic              in_range;
  logic [DATA_W-1:0] status, rd_value;

  assign trig    = bus.debug | (bus.trig_en & bus.wb_valid & (bus.wb_rd == bus.trig_rd));
  assign capture = bus.wb_valid & (state != FROZEN);

  always_comb begin
    state_n = state;
    wr_n    = wr_ptr;
    count_n = count_q;
    post_n  = post_cnt;
    if (capture) begin
      wr_n = wr_ptr + 1'b1;
      if (count_q != CW'(DEPTH)) count_n = count_q + 1'b1;
    end
    case (state)
      ARMED: begin
        if (trig) begin
          if (POST_TRIG == 0) begin
            state_n = FROZEN;
          end else begin
            state_n = POST;
            post_n  = CW'(POST_TRIG);
          end
        end
      end
      POST: begin
        // trig is deliberately ignored here; only captures advance the window
        if (capture && post_cnt != '0) begin
          post_n = post_cnt - 1'b1;
          if (post_cnt == CW'(1)) state_n = FROZEN;
        end
      end
      FROZEN: begin
        if (bus.debug) begin
          state_n = ARMED;
          wr_n    = '0;
          count_n = '0;
        end
      end
      default: state_n = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state    <= ARMED;
      wr_ptr   <= '0;
      count_q  <= '0;
      post_cnt <= '0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_n;
      count_q  <= count_n;
      post_cnt <= post_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst && capture) begin
      mem_data[wr_ptr] <= bus.wb_data;
      mem_pc[wr_ptr]   <= bus.wb_pc;
      mem_rd[wr_ptr]   <= bus.wb_rd;
    end
  end

  // Oldest valid entry sits count slots behind wr_ptr; count==DEPTH truncates to 0 offset.
  assign slot     = wr_ptr - count_q[AW-1:0] + bus.debug_input[AW-1:0];
  assign in_range = 32'(bus.debug_input) < 32'(count_q);

  always_comb begin
    status        = '0;
    status[0]     = (state == FROZEN);
    status[2:1]   = state;
    status[15:8]  = 8'(count_q);
    status[23:16] = 8'(post_cnt);
  end

  always_comb begin
    rd_value = '0;
    if (bus.debug_field == 2'd3) begin
      rd_value = status;
    end else if (in_range) begin
      case (bus.debug_field)
        2'd0:    rd_value = mem_data[slot];
        2'd1:    rd_value = mem_pc[slot];
        default: rd_value = DATA_W'(mem_rd[slot]);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) bus.debug_output <= '0;
    else     bus.debug_output <= rd_value;
  end

  assign bus.frozen = (state == FROZEN);
  assign bus.count  = count_q;
endmodule

// File: tb/tb_dbg_trace_buffer.sv
// Directed bench for dbg_trace_buffer: three instances cover default sizing,
// DEPTH=4/POST_TRIG=2 wrap and trigger behaviour, and POST_TRIG=0 immediate freeze.
module tb_dbg_trace_buffer;
  logic clk = 1'b0;
  logic Rst = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  dbg_trace_buffer_if #(.DATA_W(32), .IDX_W(5), .DEPTH(16)) bus_a ();
  dbg_trace_buffer_if #(.DATA_W(32), .IDX_W(5), .DEPTH(4))  bus_b ();
  dbg_trace_buffer_if #(.DATA_W(32), .IDX_W(5), .DEPTH(4))  bus_c ();

  dbg_trace_buffer #(.DATA_W(32), .DEPTH(16), .IDX_W(5), .POST_TRIG(4)) u_a (
    .clk(clk), .Rst(Rst), .bus(bus_a.slave));
  dbg_trace_buffer #(.DATA_W(32), .DEPTH(4), .IDX_W(5), .POST_TRIG(2)) u_b (
    .clk(clk), .Rst(Rst), .bus(bus_b.slave));
  dbg_trace_buffer #(.DATA_W(32), .DEPTH(4), .IDX_W(5), .POST_TRIG(0)) u_c (
    .clk(clk), .Rst(Rst), .bus(bus_c.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_all();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.wb_valid = 0; bus_a.wb_rd = '0; bus_a.wb_data = '0; bus_a.wb_pc = '0;
    bus_a.trig_en = 0; bus_a.trig_rd = '0; bus_a.debug = 0;
    bus_a.debug_input = '0; bus_a.debug_field = '0;
    bus_b.wb_valid = 0; bus_b.wb_rd = '0; bus_b.wb_data = '0; bus_b.wb_pc = '0;
    bus_b.trig_en = 0; bus_b.trig_rd = '0; bus_b.debug = 0;
    bus_b.debug_input = '0; bus_b.debug_field = '0;
    bus_c.wb_valid = 0; bus_c.wb_rd = '0; bus_c.wb_data = '0; bus_c.wb_pc = '0;
    bus_c.trig_en = 0; bus_c.trig_rd = '0; bus_c.debug = 0;
    bus_c.debug_input = '0; bus_c.debug_field = '0;
    #2;

    // Reset state
    reset_all();
    chk("rst_count_a", 32'(bus_a.count), 0);
    chk("rst_out_a", bus_a.debug_output, 0);
    chk("rst_frozen_a", 32'(bus_a.frozen), 0);
    chk("rst_count_b", 32'(bus_b.count), 0);
    chk("rst_frozen_c", 32'(bus_c.frozen), 0);

    // Basic capture and readback on the default instance
    bus_a.wb_valid = 1;
    bus_a.wb_rd = 5'd1; bus_a.wb_data = 32'h11; bus_a.wb_pc = 32'h0; tick();
    bus_a.wb_rd = 5'd2; bus_a.wb_data = 32'h22; bus_a.wb_pc = 32'h4; tick();
    bus_a.wb_rd = 5'd3; bus_a.wb_data = 32'h33; bus_a.wb_pc = 32'h8; tick();
    bus_a.wb_valid = 0;
    chk("a_count3", 32'(bus_a.count), 3);
    bus_a.debug_input = 5'd0; bus_a.debug_field = 2'd0; tick();
    chk("a_idx0_data", bus_a.debug_output, 32'h11);
    bus_a.debug_input = 5'd2; bus_a.debug_field = 2'd1; tick();
    chk("a_idx2_pc", bus_a.debug_output, 32'h8);
    bus_a.debug_input = 5'd1; bus_a.debug_field = 2'd2; tick();
    chk("a_idx1_rd", bus_a.debug_output, 32'h2);
    bus_a.debug_input = 5'd3; bus_a.debug_field = 2'd0; tick();
    chk("a_idx3_empty", bus_a.debug_output, 32'h0);
    bus_a.debug_input = 5'd3; bus_a.debug_field = 2'd3; tick();
    chk("a_status", bus_a.debug_output, 32'h0000_0300);

    // Wrap on DEPTH=4: six writes, oldest two overwritten
    bus_b.wb_valid = 1;
    for (int i = 1; i <= 6; i++) begin
      bus_b.wb_rd = 5'(i); bus_b.wb_data = 32'(i); bus_b.wb_pc = 32'(4 * i);
      tick();
    end
    bus_b.wb_valid = 0;
    chk("b_wrap_count", 32'(bus_b.count), 4);
    bus_b.debug_input = 5'd0; bus_b.debug_field = 2'd0; tick();
    chk("b_wrap_idx0", bus_b.debug_output, 32'd3);
    bus_b.debug_input = 5'd3; tick();
    chk("b_wrap_idx3", bus_b.debug_output, 32'd6);

    // rd-match trigger with two post entries
    reset_all();
    bus_b.trig_en = 1; bus_b.trig_rd = 5'd5; bus_b.wb_valid = 1;
    bus_b.wb_rd = 5'd1; bus_b.wb_data = 32'h1; tick();
    bus_b.wb_rd = 5'd5; bus_b.wb_data = 32'h5; tick();
    bus_b.wb_rd = 5'd6; bus_b.wb_data = 32'h6; tick();
    chk("b_not_frozen_yet", 32'(bus_b.frozen), 0);
    bus_b.wb_rd = 5'd7; bus_b.wb_data = 32'h7;
    bus_b.debug_input = 5'd0; bus_b.debug_field = 2'd3; tick();
    chk("b_status_post", bus_b.debug_output, 32'h0001_0302);
    chk("b_frozen", 32'(bus_b.frozen), 1);
    bus_b.wb_rd = 5'd8; bus_b.wb_data = 32'h8; tick();
    bus_b.wb_valid = 0;
    chk("b_frozen_count", 32'(bus_b.count), 4);
    bus_b.debug_field = 2'd2;
    bus_b.debug_input = 5'd0; tick(); chk("b_rd_idx0", bus_b.debug_output, 32'd1);
    bus_b.debug_input = 5'd1; tick(); chk("b_rd_idx1", bus_b.debug_output, 32'd5);
    bus_b.debug_input = 5'd2; tick(); chk("b_rd_idx2", bus_b.debug_output, 32'd6);
    bus_b.debug_input = 5'd3; tick(); chk("b_rd_idx3", bus_b.debug_output, 32'd7);
    bus_b.debug_field = 2'd3; tick();
    chk("b_status_frozen", bus_b.debug_output, 32'h0000_0405);

    // Re-arm: the write in the re-arm cycle is dropped
    bus_b.trig_en = 0;
    bus_b.debug = 1; bus_b.wb_valid = 1; bus_b.wb_rd = 5'd9; bus_b.wb_data = 32'h99; tick();
    bus_b.debug = 0;
    chk("b_rearm_frozen", 32'(bus_b.frozen), 0);
    chk("b_rearm_count", 32'(bus_b.count), 0);
    bus_b.wb_rd = 5'd10; bus_b.wb_data = 32'hAA; tick();
    bus_b.wb_valid = 0;
    bus_b.debug_input = 5'd0; bus_b.debug_field = 2'd0; tick();
    chk("b_rearm_data", bus_b.debug_output, 32'hAA);
    chk("b_rearm_count1", 32'(bus_b.count), 1);

    // Manual trigger with POST_TRIG=0 freezes immediately, trigger write kept
    bus_c.debug = 1; bus_c.wb_valid = 1; bus_c.wb_rd = 5'd4; bus_c.wb_data = 32'h9; tick();
    bus_c.debug = 0; bus_c.wb_valid = 0;
    chk("c_frozen", 32'(bus_c.frozen), 1);
    chk("c_count", 32'(bus_c.count), 1);
    bus_c.debug_input = 5'd0; bus_c.debug_field = 2'd0; tick();
    chk("c_data", bus_c.debug_output, 32'h9);
    bus_c.debug_field = 2'd3; tick();
    chk("c_status", bus_c.debug_output, 32'h0000_0105);

    // Reset during POST discards the trace
    bus_b.trig_en = 1; bus_b.trig_rd = 5'd5;
    bus_b.wb_valid = 1; bus_b.wb_rd = 5'd5; bus_b.wb_data = 32'h55; tick();
    bus_b.wb_valid = 0; bus_b.debug_field = 2'd3; bus_b.debug_input = 5'd0; tick();
    chk("b_in_post", bus_b.debug_output, 32'h0002_0202);
    reset_all();
    chk("b_rst_count", 32'(bus_b.count), 0);
    chk("b_rst_out", bus_b.debug_output, 32'h0);
    tick();
    chk("b_rst_status", bus_b.debug_output, 32'h0);

    // Simultaneous debug pulse and rd-match: one trigger; later pulses ignored in POST
    bus_b.debug = 1; bus_b.wb_valid = 1; bus_b.wb_rd = 5'd5; bus_b.wb_data = 32'h50; tick();
    bus_b.wb_valid = 0; tick();
    chk("b_sim_status", bus_b.debug_output, 32'h0002_0102);
    bus_b.debug = 0; tick();
    chk("b_sim_post_hold", bus_b.debug_output, 32'h0002_0102);
    bus_b.wb_valid = 1; bus_b.wb_rd = 5'd6; bus_b.wb_data = 32'h60; tick();
    bus_b.wb_valid = 0; tick();
    chk("b_sim_post_dec", bus_b.debug_output, 32'h0001_0202);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
